servo_setpoint: RTL

SERVO_SETPOINT -- requirements
Module: servo_setpoint

---
 rtl/servo_setpoint.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/servo_setpoint.sv
// servo_setpoint: converts angle commands (0..180 deg) into a servo PWM pulse
// width. Each command is scaled to a target width by a sequential divider.
// duty_cycle moves toward that target only at frame boundaries, so it stays
// in step with the downstream PWM counter.
//
// Build option: SERVO_SETPOINT_RAMP_EN
//   defined   - duty_cycle slews toward the target by at most RAMP_STEP per frame
//   undefined - duty_cycle loads the target directly on the next frame_tick
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous, active-low reset
//   cmd_valid   angle command valid
//   cmd_angle   target angle in degrees; values above 180 are clamped to 180
//   cmd_ready   high while idle; a command is taken when valid and ready are both high
//   duty_cycle  pulse width in clocks (PWM duty input)
//   period      frame length in clocks (PWM period input), constant
//   frame_tick  one-cycle pulse on the last clock of each frame
//   at_target   duty_cycle equals the target and no conversion is pending
module servo_setpoint #(
    parameter int unsigned CLK_FREQ  = 25000000,
    parameter int unsigned PWM_FREQ  = 50,
    parameter int unsigned MIN_PULSE = 25000,
    parameter int unsigned MAX_PULSE = 50000,
    parameter int unsigned RAMP_STEP = 2500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_angle,
    output logic        cmd_ready,
    output logic [31:0] duty_cycle,
    output logic [31:0] period,
    output logic        frame_tick,
    output logic        at_target
);

    localparam int unsigned PERIOD    = CLK_FREQ / PWM_FREQ;
    localparam int unsigned SPAN      = MAX_PULSE - MIN_PULSE;
    localparam int unsigned MID_PULSE = (MIN_PULSE + MAX_PULSE) / 2;
    localparam int unsigned ANGLE_MAX = 180;
    localparam int unsigned ITER_W    = 6;
    localparam int unsigned LAST_ITER = 32;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    logic [0:0]        r_state;
    logic [31:0]       r_frame_cnt;
    logic              r_frame_tick;
    logic [7:0]        r_angle;
    logic [31:0]       r_quo;
    logic [31:0]       r_rem;
    logic [ITER_W-1:0] r_iter;
    logic [31:0]       r_target;
    logic [31:0]       r_duty;
    logic              r_cmd_ready;
    logic              r_at_target;

    logic [0:0]        w_state_nxt;
    logic [31:0]       w_frame_nxt;
    logic [7:0]        w_angle_nxt;
    logic [31:0]       w_quo_nxt;
    logic [31:0]       w_rem_nxt;
    logic [ITER_W-1:0] w_iter_nxt;
    logic [31:0]       w_target_nxt;
    logic [31:0]       w_duty_nxt;
    logic [32:0]       w_rem_shift;

    // Frame counter wraps at PERIOD-1; tick is registered to line up with that count
    assign w_frame_nxt = (r_frame_cnt == 32'(PERIOD - 1)) ? 32'd0 : r_frame_cnt + 32'd1;

    // Command FSM and restoring divider: angle*SPAN / 180, one quotient bit per clock
    always_comb begin
        w_state_nxt  = r_state;
        w_angle_nxt  = r_angle;
        w_quo_nxt    = r_quo;
        w_rem_nxt    = r_rem;
        w_iter_nxt   = r_iter;
        w_target_nxt = r_target;
        w_rem_shift  = {r_rem, r_quo[31]};
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_state_nxt = S_CALC;
                    w_angle_nxt = (cmd_angle > 8'(ANGLE_MAX)) ? 8'(ANGLE_MAX) : cmd_angle;
                    w_iter_nxt  = '0;
                end
            end
            S_CALC: begin
                if (r_iter == '0) begin
                    w_quo_nxt  = 32'(r_angle) * 32'(SPAN);
                    w_rem_nxt  = '0;
                    w_iter_nxt = ITER_W'(1);
                end else begin
                    if (w_rem_shift >= 33'(ANGLE_MAX)) begin
                        w_rem_nxt = 32'(w_rem_shift - 33'(ANGLE_MAX));
                        w_quo_nxt = {r_quo[30:0], 1'b1};
                    end else begin
                        w_rem_nxt = 32'(w_rem_shift);
                        w_quo_nxt = {r_quo[30:0], 1'b0};
                    end
                    w_iter_nxt = r_iter + ITER_W'(1);
                    if (r_iter == ITER_W'(LAST_ITER)) begin
                        w_target_nxt = 32'(MIN_PULSE) + w_quo_nxt;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Duty update on frame_tick only, from the target as it stood before this edge
    always_comb begin
        w_duty_nxt = r_duty;
        if (r_frame_tick) begin
`ifdef SERVO_SETPOINT_RAMP_EN
            if (r_duty < r_target) begin
                w_duty_nxt = ((r_target - r_duty) > 32'(RAMP_STEP)) ? r_duty + 32'(RAMP_STEP) : r_target;
            end else if (r_duty > r_target) begin
                w_duty_nxt = ((r_duty - r_target) > 32'(RAMP_STEP)) ? r_duty - 32'(RAMP_STEP) : r_target;
            end
`else
            w_duty_nxt = r_target;
`endif
        end
    end

`ifndef SERVO_SETPOINT_RAMP_EN
    logic w_unused_ramp;
    assign w_unused_ramp = ^32'(RAMP_STEP);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
            r_angle      <= '0;
            r_quo        <= '0;
            r_rem        <= '0;
            r_iter       <= '0;
            r_target     <= 32'(MID_PULSE);
            r_duty       <= 32'(MID_PULSE);
            r_cmd_ready  <= 1'b0;
            r_at_target  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_cnt  <= w_frame_nxt;
            r_frame_tick <= (w_frame_nxt == 32'(PERIOD - 1));
            r_angle      <= w_angle_nxt;
            r_quo        <= w_quo_nxt;
            r_rem        <= w_rem_nxt;
            r_iter       <= w_iter_nxt;
            r_target     <= w_target_nxt;
            r_duty       <= w_duty_nxt;
            r_cmd_ready  <= (w_state_nxt == S_IDLE);
            r_at_target  <= (w_duty_nxt == w_target_nxt) && (w_state_nxt == S_IDLE);
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign duty_cycle = r_duty;
    assign period     = 32'(PERIOD);
    assign frame_tick = r_frame_tick;
    assign at_target  = r_at_target;

endmodule
